uart_receiver: RTL and testbench

//  8N1 serial receiver; sits between the board RX pin and the on-chip byte FIFO.

---
 rtl/uart_receiver.sv | 133 +++++++++++++
 tb/tb_uart_receiver.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 serial receiver: synchronises the RX pin, samples LSB-first data at bit
// centre, checks the stop bit and hands good bytes to a ready/valid consumer.
module uart_receiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       rx_busy,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic [2:0]       state;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  assign rx_s    = sync_q[1];
  assign rx_busy = (state != IDLE);

  // NOTE: every register here is written with <= so all reads in this block
  // see the pre-edge value; blocking assignments would reorder the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q         <= 2'b11;
      state          <= IDLE;
      clk_cnt        <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], serial_in};

      // Flags are single-cycle pulses; a later assignment below overrides.
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            clk_cnt <= '0;
          end
        end

        START: begin
          if (clk_cnt == SAMPLE_LAST) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              clk_cnt <= '0;
              bit_cnt <= '0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end

        DATA: begin
          if (clk_cnt == SYMBOL_LAST) begin
            shreg[bit_cnt] <= rx_s;
            clk_cnt        <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end

        STOP: begin
          // Leaving at mid-stop-bit gives half a bit of slack for the next start.
          if (clk_cnt == SYMBOL_LAST) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              framing_error <= 1'b1;
              state         <= BREAK;
            end else begin
              state <= IDLE;
              if (!data_out_valid || data_out_ready) begin
                data_out       <= shreg;
                data_out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end

        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 10 clk/bit: single bytes, back-to-back
// frames, overrun, framing error, start glitch and mid-frame reset.
module tb_uart_receiver;

  localparam int BIT_CLKS = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b1;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready = 1'b1;
  logic       rx_busy;
  logic       framing_error;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] byte_q[$];
  int         fe_cnt = 0;
  int         ovr_cnt = 0;
  int         both_cnt = 0;
  int         valid_rise_cnt = 0;
  int         hold_err = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_receiver #(
    .CLOCK_FREQ(1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .rx_busy       (rx_busy),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after posedge; outputs are observed at negedge.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_out_valid && data_out_ready) byte_q.push_back(data_out);
      if (framing_error) fe_cnt++;
      if (overrun) ovr_cnt++;
      if (framing_error && overrun) both_cnt++;
      if (data_out_valid && !prev_valid) valid_rise_cnt++;
      if (prev_valid && !prev_ready && (data_out_valid !== 1'b1 || data_out !== prev_data))
        hold_err++;
    end
    prev_valid = data_out_valid && !reset;
    prev_ready = data_out_ready;
    prev_data  = data_out;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input logic b, input int n);
    serial_in = b;
    tick(n);
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(data[i], BIT_CLKS);
    drive_bit(stop_bit, BIT_CLKS);
    serial_in = 1'b1;
  endtask

  task automatic expect_byte(input string name, input logic [7:0] exp);
    logic [7:0] got;
    checks++;
    if (byte_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no byte received, expected %02h", name, exp);
    end else begin
      got = byte_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: data_out got %02h expected %02h", name, got, exp);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    checks++;
    if ({data_out, data_out_valid, rx_busy, framing_error, overrun} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got data=%02h v=%b busy=%b fe=%b ovr=%b expected all zero",
               data_out, data_out_valid, rx_busy, framing_error, overrun);
    end
    reset = 1'b0;
    tick(5);
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: rx_busy got %b expected 0", rx_busy);
    end
  endtask

  task automatic test_single_byte;
    int rise0, fe0, ovr0;
    rise0 = valid_rise_cnt; fe0 = fe_cnt; ovr0 = ovr_cnt;
    data_out_ready = 1'b1;
    send_byte(8'hA5, 1'b1);
    tick(5);
    expect_byte("single_a5", 8'hA5);
    checks++;
    if (valid_rise_cnt - rise0 != 1 || fe_cnt != fe0 || ovr_cnt != ovr0) begin
      errors++;
      $display("FAIL single_flags: valid pulses=%0d fe=%0d ovr=%0d expected 1/0/0",
               valid_rise_cnt - rise0, fe_cnt - fe0, ovr_cnt - ovr0);
    end
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_valid_drop: valid got %b expected 0", data_out_valid);
    end
  endtask

  task automatic test_back_to_back;
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    tick(5);
    checks++;
    if (byte_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d bytes expected 2", byte_q.size());
    end
    expect_byte("b2b_first", 8'h3C);
    expect_byte("b2b_second", 8'hC3);
  endtask

  task automatic test_overrun;
    int ovr0, fe0;
    ovr0 = ovr_cnt; fe0 = fe_cnt;
    data_out_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    tick(5);
    send_byte(8'h22, 1'b1);
    tick(5);
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h11) begin
      errors++;
      $display("FAIL overrun_hold: got v=%b data=%02h expected v=1 data=11",
               data_out_valid, data_out);
    end
    checks++;
    if (ovr_cnt - ovr0 != 1 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL overrun_pulse: overrun pulses=%0d fe=%0d expected 1/0",
               ovr_cnt - ovr0, fe_cnt - fe0);
    end
    data_out_ready = 1'b1;
    tick(3);
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_release: valid got %b expected 0", data_out_valid);
    end
    checks++;
    if (byte_q.size() != 1) begin
      errors++;
      $display("FAIL overrun_count: got %0d bytes expected 1", byte_q.size());
    end
    expect_byte("overrun_data", 8'h11);
  endtask

  task automatic test_framing;
    int fe0, rise0;
    fe0 = fe_cnt; rise0 = valid_rise_cnt;
    send_byte(8'h55, 1'b0);
    drive_bit(1'b0, 30);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL framing_break_busy: rx_busy got %b expected 1", rx_busy);
    end
    drive_bit(1'b1, 20);
    checks++;
    if (fe_cnt - fe0 != 1 || valid_rise_cnt != rise0) begin
      errors++;
      $display("FAIL framing_pulse: fe pulses=%0d valid pulses=%0d expected 1/0",
               fe_cnt - fe0, valid_rise_cnt - rise0);
    end
    send_byte(8'h7E, 1'b1);
    tick(5);
    expect_byte("framing_recover", 8'h7E);
  endtask

  task automatic test_glitch;
    int fe0, ovr0, rise0;
    fe0 = fe_cnt; ovr0 = ovr_cnt; rise0 = valid_rise_cnt;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 30);
    checks++;
    if (rx_busy !== 1'b0 || valid_rise_cnt != rise0 || fe_cnt != fe0 || ovr_cnt != ovr0) begin
      errors++;
      $display("FAIL glitch: busy=%b valid=%0d fe=%0d ovr=%0d expected 0/0/0/0",
               rx_busy, valid_rise_cnt - rise0, fe_cnt - fe0, ovr_cnt - ovr0);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    d = 8'hF0;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLKS);
    drive_bit(d[4], 5);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: rx_busy got %b expected 1", rx_busy);
    end
    reset = 1'b1;
    serial_in = 1'b1;
    tick(2);
    checks++;
    if ({data_out, data_out_valid, rx_busy, framing_error, overrun} !== 12'h000) begin
      errors++;
      $display("FAIL midframe_reset: got data=%02h v=%b busy=%b fe=%b ovr=%b expected all zero",
               data_out, data_out_valid, rx_busy, framing_error, overrun);
    end
    reset = 1'b0;
    tick(20);
    send_byte(8'h0F, 1'b1);
    tick(5);
    checks++;
    if (byte_q.size() != 1) begin
      errors++;
      $display("FAIL midframe_count: got %0d bytes expected 1", byte_q.size());
    end
    expect_byte("midframe_next", 8'h0F);
  endtask

  task automatic test_invariants;
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL flags_exclusive: %0d cycles with both flags, expected 0", both_cnt);
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL data_hold: %0d cycles unstable while stalled, expected 0", hold_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_glitch();
    test_reset_mid_frame();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
